ps2_host_tx_fifo: RTL
=====================

Name: ps2_host_tx_fifo

Overview:
- Parametrised next-generation PS/2 host transmitter, replacing the fixed single-byte send path (transmitter + clock noise filter + bit counter).
- Adds a TX FIFO, configurable inhibit and filter lengths, device ACK checking, and a frame timeout with error reporting.
- Sits between the command logic (keyboard LED/typematic commands) and the open-drain ps2_c/ps2_d pads.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of two, ≥2.
- FILTER_LEN, 8, consecutive equal ps2_c samples required to change the filtered clock.
- INHIBIT_CYCLES, 5000, clk cycles ps2_c is held low before the request (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000, max clk cycles from clock release to ACK sample (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- datain  in  8  byte to queue.
- tx_write  in  1  queue datain this cycle; ignored when tx_full=1.
- ps2_c  inout  1  PS/2 clock, open-drain: drives 0 or z only.
- ps2_d  inout  1  PS/2 data, open-drain: drives 0 or z only.
- tx_full  out  1  FIFO full.
- tx_idle  out  1  FSM in IDLE and FIFO empty.
- tx_done  out  1  one-cycle pulse: frame ACKed.
- tx_err  out  1  one-cycle pulse: frame failed.
- err_code  out  2  valid with tx_err: 01 = NACK, 10 = timeout; otherwise holds last value.

Behaviour:
- Reset: both pads released (z), FIFO emptied, FSM=IDLE, filter register all ones, edge/bit/timer counters 0. Outputs: tx_idle=1, tx_full=0, tx_done=0, tx_err=0, err_code=00. Reset mid-frame aborts immediately; the next cycle both lines are z. No done or err pulse is generated for the aborted frame.
- Filter: ps2_c is sampled into a FILTER_LEN shift register. The filtered clock goes to 0 when all bits are 0 and to 1 when all bits are 1; otherwise it holds. fall_edge is a one-cycle pulse on the filtered 1→0 transition. Latency from pad to fall_edge is FILTER_LEN+1 cycles.
- FIFO: push when tx_write && !tx_full. A write while full is dropped with no state change. Pop occurs on the IDLE→INHIBIT transition. Simultaneous push and pop is legal, and the count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: if FIFO is non-empty, pop into the shift register, compute odd parity (parity bit = ~^byte), and go to INHIBIT.
  - INHIBIT: drive ps2_c=0 for INHIBIT_CYCLES cycles. Drive ps2_d=0 on the last inhibit cycle. Go to REQ.
  - REQ: release ps2_c and keep ps2_d=0 (start bit). Clear the edge counter, start the timeout timer, go to DATA.
  - DATA: count fall_edge events. On edge n=1..8, drive data bit n-1 (LSB first; 0 → drive 0, 1 → z). Edge 9 drives parity. Edge 10 releases ps2_d (stop bit), then go to ACK.
  - ACK: on the next fall_edge, sample ps2_d. A 0 gives tx_done; a 1 gives tx_err with err_code=01. Both go to WAIT.
  - WAIT: remain until the filtered clock and ps2_d are both 1, then go to IDLE. A new frame may start the following cycle.
- Timeout: if the timer reaches TIMEOUT_CYCLES in REQ, DATA or ACK, release both lines, pulse tx_err with err_code=10, and go to WAIT.
  - The timeout takes priority over a fall_edge in the same cycle.
  - The timer does not run in INHIBIT.
- fall_edge pulses in IDLE, INHIBIT or WAIT are ignored.
- tx_done and tx_err are never asserted together.
- tx_write during any state only pushes to the FIFO.

Test Plan (sim overrides: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, device model clocks at 40 cycles/half-period, FILTER_LEN=8):
- Single byte: write 0xED, model ACKs → ps2_c low for 20 cycles; then ps2_d sequence is start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop z. One tx_done pulse follows; tx_idle returns to 1 after WAIT.
- NACK: write 0xF4, model leaves ps2_d high at the ACK edge → tx_err=1 with err_code=01, no tx_done, lines released.
- Timeout: write 0xFF, model never clocks → tx_err with err_code=10 exactly 2000 cycles after REQ; ps2_c and ps2_d are z.
- FIFO burst: 5 back-to-back writes 0x01..0x05 while IDLE.
  - tx_full=1 after the 4th unpopped entry.
  - 0x05 is dropped only if the FIFO is full at that cycle.
  - The frames that go out carry the queued bytes in write order, each ACKed.
- Glitch: inject ps2_c low pulses of 3 and 7 cycles during DATA → no extra fall_edge and the bit count is unaffected. A 9-cycle low pulse counts as one edge.
- Reset mid-frame: assert rst at edge 5 of byte 0xAA with 2 bytes queued → next cycle both lines are z, tx_idle=1, FIFO empty, no done/err pulse.

Source files
------------

// File: rtl/ps2_host_tx_fifo.sv
// PS/2 host-to-device transmitter: byte FIFO feeding a frame FSM with filtered
// device clock, open-drain pad drive, device ACK check and frame timeout.
module ps2_host_tx_fifo #(
   parameter int FIFO_DEPTH     = 4,
   parameter int FILTER_LEN     = 8,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] datain,
   input  logic       tx_write,
   inout  wire        ps2_c,
   inout  wire        ps2_d,
   output logic       tx_full,
   output logic       tx_idle,
   output logic       tx_done,
   output logic       tx_err,
   output logic [1:0] err_code
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, ACK, WAIT} state_t;

   state_t                state_reg;
   logic [7:0]            mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_reg;
   logic [AW-1:0]         rd_ptr_reg;
   logic [CW-1:0]         count_reg;
   logic [FILTER_LEN-1:0] filt_reg;
   logic                  clk_f_reg;
   logic                  fall_reg;
   logic [1:0]            d_sync_reg;
   logic [9:0]            shift_reg;
   logic [3:0]            edge_cnt_reg;
   logic [IW-1:0]         inh_cnt_reg;
   logic [TW-1:0]         timer_reg;
   logic                  c_low_reg;
   logic                  d_low_reg;
   logic                  done_reg;
   logic                  err_reg;
   logic [1:0]            code_reg;

   logic push;
   logic pop;
   logic all_zero;
   logic all_one;

   assign ps2_c    = c_low_reg ? 1'b0 : 1'bz;
   assign ps2_d    = d_low_reg ? 1'b0 : 1'bz;
   assign tx_full  = (count_reg == CW'(FIFO_DEPTH));
   assign tx_idle  = (state_reg == IDLE) && (count_reg == '0);
   assign tx_done  = done_reg;
   assign tx_err   = err_reg;
   assign err_code = code_reg;

   assign push     = tx_write && !tx_full;
   assign pop      = (state_reg == IDLE) && (count_reg != '0);
   assign all_zero = ~|filt_reg;
   assign all_one  = &filt_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= datain;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Filtered clock only moves once the whole window agrees; fall_reg marks 1->0.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_reg   <= '1;
         clk_f_reg  <= 1'b1;
         fall_reg   <= 1'b0;
         d_sync_reg <= 2'b11;
      end else begin
         filt_reg   <= {filt_reg[FILTER_LEN-2:0], ps2_c};
         d_sync_reg <= {d_sync_reg[0], ps2_d};
         fall_reg   <= clk_f_reg && all_zero;
         if (all_zero) begin
            clk_f_reg <= 1'b0;
         end else if (all_one) begin
            clk_f_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         shift_reg    <= '1;
         edge_cnt_reg <= '0;
         inh_cnt_reg  <= '0;
         timer_reg    <= '0;
         c_low_reg    <= 1'b0;
         d_low_reg    <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         code_reg     <= 2'b00;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (count_reg != '0) begin
                  // Frame after start bit: 8 data bits LSB first, odd parity, stop.
                  shift_reg   <= {1'b1, ~^mem[rd_ptr_reg], mem[rd_ptr_reg]};
                  inh_cnt_reg <= '0;
                  c_low_reg   <= 1'b1;
                  d_low_reg   <= (INHIBIT_CYCLES == 1);
                  state_reg   <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (inh_cnt_reg == IW'(INHIBIT_CYCLES - 1)) begin
                  c_low_reg <= 1'b0;
                  d_low_reg <= 1'b1;
                  timer_reg <= '0;
                  state_reg <= REQ;
               end else begin
                  inh_cnt_reg <= inh_cnt_reg + 1'b1;
                  if (inh_cnt_reg == IW'(INHIBIT_CYCLES - 2)) begin
                     d_low_reg <= 1'b1;
                  end
               end
            end
            REQ, DATA, ACK: begin
               timer_reg <= timer_reg + 1'b1;
               if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                  c_low_reg <= 1'b0;
                  d_low_reg <= 1'b0;
                  err_reg   <= 1'b1;
                  code_reg  <= 2'b10;
                  state_reg <= WAIT;
               end else if (state_reg == REQ) begin
                  edge_cnt_reg <= '0;
                  state_reg    <= DATA;
               end else if (fall_reg) begin
                  if (state_reg == DATA) begin
                     d_low_reg    <= ~shift_reg[0];
                     shift_reg    <= {1'b1, shift_reg[9:1]};
                     edge_cnt_reg <= edge_cnt_reg + 1'b1;
                     if (edge_cnt_reg == 4'd9) begin
                        state_reg <= ACK;
                     end
                  end else begin
                     if (d_sync_reg[1]) begin
                        err_reg  <= 1'b1;
                        code_reg <= 2'b01;
                     end else begin
                        done_reg <= 1'b1;
                     end
                     state_reg <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (clk_f_reg && d_sync_reg[1]) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
